lock_sequencer: RTL
===================

Name: lock_sequencer

Overview:
- Controller that sequences the 4-digit password entry path into a complete lock: it collects digit pulses, compares a full code, counts failed attempts, enforces a lockout window, and holds an unlock window.
- It also allows the stored code to be reprogrammed while unlocked.
- Sits after the per-switch one_shot bank; its disp_state drives the same status display encoding used by the password block.

Parameters:
- MAX_FAILS, 3, consecutive wrong codes that trigger lockout (1..7).
- LOCK_CYCLES, 50000000, clock cycles spent in LOCKOUT.
- OPEN_CYCLES, 250000000, clock cycles the lock stays open before auto-relock.
- ENTRY_TIMEOUT, 150000000, idle cycles allowed between digits during ENTRY/PROG before abort.
- DEFAULT_CODE, 16'h2016, reset code, four 4-bit digit indices, first digit in [15:12].

Ports:
- clk  in  1  system clock
- rst_a_p  in  1  asynchronous reset, active-high
- digit_pulse  in  10  one-cycle pulses from one_shot bank, bit i = digit i
- prog_req  in  1  one-cycle pulse requesting code reprogramming
- unlocked  out  1  high while in OPEN
- locked_out  out  1  high while in LOCKOUT
- disp_state  out  2  0 nothing, 1 error/lockout, 2 open, 3 entry or programming in process
- digit_count  out  3  digits captured in current ENTRY/PROG sequence (0..4)
- fail_count  out  3  consecutive failed attempts

Behaviour:
- One clock; reset is asynchronous and active-high (rst_a_p); all state elements clear on reset.
- Reset values: state IDLE, stored code = DEFAULT_CODE, digit_count 0, fail_count 0, timer 0. Outputs then read unlocked 0, locked_out 0, disp_state 0.
- Outputs are Moore decodes of the state register and counters: a pulse sampled at edge N is reflected in the outputs immediately after edge N.
- Valid digit: digit_pulse has exactly one bit set, with index 0..9 encoded 4 bits. Invalid digit: two or more bits set. An all-zero pulse is no event.
- States: IDLE, ENTRY, ERROR, LOCKOUT, OPEN, PROG.
- IDLE (disp 0):
  - Any event (valid or invalid) is captured as digit 1 and the state moves to ENTRY with digit_count 1.
  - prog_req is ignored.
- ENTRY (disp 3):
  - Each event is stored and increments digit_count.
  - An invalid event sets a sticky bad flag.
  - The comparison happens only on the 4th event, never earlier. If the code matches and the bad flag is clear, go to OPEN and clear fail_count. Otherwise increment fail_count; go to LOCKOUT if fail_count reaches MAX_FAILS, else go to ERROR.
- ENTRY timeout:
  - The timer restarts on each event.
  - If ENTRY_TIMEOUT cycles pass with no event, go to IDLE. Captured digits are discarded and fail_count is unchanged.
- ERROR (disp 1):
  - Held until any event, which is consumed (not captured as a digit), then go to IDLE.
  - Also returns to IDLE after an ENTRY_TIMEOUT of no events.
- LOCKOUT (disp 1, locked_out 1):
  - All events and prog_req are ignored for exactly LOCK_CYCLES cycles.
  - Then go to IDLE and clear fail_count.
- OPEN (disp 2, unlocked 1):
  - After OPEN_CYCLES cycles, go to IDLE.
  - Any digit event relocks: go to IDLE; the event is not captured.
  - prog_req goes to PROG.
  - prog_req and a digit event in the same cycle: prog_req wins and the digit is dropped.
- PROG (disp 3):
  - Collects 4 valid digits into a shadow register.
  - On the 4th digit the stored code is replaced atomically, then go to IDLE.
  - An invalid event or an ENTRY_TIMEOUT aborts to IDLE with the stored code unchanged.
  - prog_req is ignored.
- digit_count returns to 0 on every exit from ENTRY/PROG.
- fail_count saturates at MAX_FAILS.
- Timer width: clog2 of the largest of LOCK_CYCLES, OPEN_CYCLES, ENTRY_TIMEOUT. The timer clears on every state change.
- Reset asserted mid-operation in any state: return to IDLE immediately. The stored code reverts to DEFAULT_CODE.

Test Plan:
- All benches use MAX_FAILS=3, LOCK_CYCLES=20, OPEN_CYCLES=10, ENTRY_TIMEOUT=15.
- Pulse digits 2,0,1,6 five cycles apart -> disp_state 3 after the first pulse; after the 4th, unlocked=1 and disp_state=2 for exactly 10 cycles, then IDLE with disp 0.
- Enter 2,0,1,5 three times, clearing ERROR with one pulse each time -> fail_count 1, 2, then locked_out=1 for 20 cycles ignoring pulses, then IDLE with fail_count 0.
- Enter 2,0,1,6 where the second pulse is 10'b0000000011 -> no early abort; after the 4th event, ERROR with fail_count 1.
- Unlock, then pulse prog_req and enter 7,7,3,1 -> IDLE. Code 2016 now fails and code 7731 opens. Assert reset -> code 2016 opens again.
- Enter 2,0 then wait 15 cycles -> IDLE, digit_count 0, fail_count unchanged. In OPEN, prog_req and digit 4 in the same cycle -> PROG.
- Assert rst_a_p mid-LOCKOUT, asynchronously between clock edges -> locked_out drops before the next edge; state IDLE, fail_count 0.

Source files
------------

// File: rtl/lock_sequencer.sv
// lock_sequencer: 4-digit code lock with fail counting, lockout, open window and code reprogramming
module lock_sequencer #(
   parameter int          MAX_FAILS     = 3,
   parameter int          LOCK_CYCLES   = 50000000,
   parameter int          OPEN_CYCLES   = 250000000,
   parameter int          ENTRY_TIMEOUT = 150000000,
   parameter logic [15:0] DEFAULT_CODE  = 16'h2016
) (
   input  logic       clk,
   input  logic       rst_a_p,
   input  logic [9:0] digit_pulse,
   input  logic       prog_req,
   output logic       unlocked,
   output logic       locked_out,
   output logic [1:0] disp_state,
   output logic [2:0] digit_count,
   output logic [2:0] fail_count
);
   localparam int MAXC = (LOCK_CYCLES > OPEN_CYCLES)
                         ? ((LOCK_CYCLES > ENTRY_TIMEOUT) ? LOCK_CYCLES : ENTRY_TIMEOUT)
                         : ((OPEN_CYCLES > ENTRY_TIMEOUT) ? OPEN_CYCLES : ENTRY_TIMEOUT);
   localparam int TW = (MAXC > 1) ? $clog2(MAXC) : 1;
   typedef enum logic [2:0] {IDLE, ENTRY, ERROR, LOCKOUT, OPEN, PROG} state_t;
   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [15:0]   code_q, code_d, shift_q, shift_d;
   logic [2:0]    count_q, count_d, fail_q, fail_d, fail_inc;
   logic          bad_q, bad_d;
   logic          ev, valid, match, t_entry, t_lock, t_open;
   logic [3:0]    dig;
   always_comb begin
      dig = '0;
      for (int i = 0; i < 10; i++)
         if (digit_pulse[i]) dig = 4'(i);
   end
   assign ev       = |digit_pulse;
   assign valid    = $onehot(digit_pulse);
   assign match    = valid && !bad_q && ({shift_q[11:0], dig} == code_q);
   assign t_entry  = timer_q == TW'(ENTRY_TIMEOUT - 1);
   assign t_lock   = timer_q == TW'(LOCK_CYCLES - 1);
   assign t_open   = timer_q == TW'(OPEN_CYCLES - 1);
   assign fail_inc = (fail_q < 3'(MAX_FAILS)) ? fail_q + 3'd1 : fail_q;
   always_comb begin
      state_d = state_q;
      timer_d = timer_q + 1'b1;
      code_d  = code_q;
      shift_d = shift_q;
      count_d = count_q;
      fail_d  = fail_q;
      bad_d   = bad_q;
      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (ev) begin
               state_d = ENTRY;
               shift_d = {12'h000, dig};
               count_d = 3'd1;
               bad_d   = !valid;
            end
         end
         ENTRY: begin
            if (ev) begin
               timer_d = '0;
               shift_d = {shift_q[11:0], dig};
               count_d = count_q + 3'd1;
               bad_d   = bad_q | !valid;
               if (count_q == 3'd3) begin
                  count_d = '0;
                  fail_d  = match ? 3'd0 : fail_inc;
                  state_d = match ? OPEN : (fail_inc >= 3'(MAX_FAILS)) ? LOCKOUT : ERROR;
               end
            end else if (t_entry) begin
               state_d = IDLE;
               count_d = '0;
            end
         end
         ERROR: if (ev || t_entry) state_d = IDLE;
         LOCKOUT: begin
            if (t_lock) begin
               state_d = IDLE;
               fail_d  = '0;
            end
         end
         OPEN: begin
            // prog_req takes priority over a simultaneous relock digit
            if (prog_req) state_d = PROG;
            else if (ev || t_open) state_d = IDLE;
         end
         PROG: begin
            if (ev) begin
               timer_d = '0;
               shift_d = {shift_q[11:0], dig};
               count_d = count_q + 3'd1;
               if (!valid || count_q == 3'd3) begin
                  state_d = IDLE;
                  count_d = '0;
               end
               if (valid && count_q == 3'd3) code_d = {shift_q[11:0], dig};
            end else if (t_entry) begin
               state_d = IDLE;
               count_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) timer_d = '0;
   end
   always_ff @(posedge clk or posedge rst_a_p) begin
      if (rst_a_p) begin
         state_q <= IDLE;
         timer_q <= '0;
         code_q  <= DEFAULT_CODE;
         shift_q <= '0;
         count_q <= '0;
         fail_q  <= '0;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         code_q  <= code_d;
         shift_q <= shift_d;
         count_q <= count_d;
         fail_q  <= fail_d;
         bad_q   <= bad_d;
      end
   end
   assign unlocked    = state_q == OPEN;
   assign locked_out  = state_q == LOCKOUT;
   assign disp_state  = (state_q == OPEN) ? 2'd2
                      : (state_q == ERROR || state_q == LOCKOUT) ? 2'd1
                      : (state_q == ENTRY || state_q == PROG) ? 2'd3 : 2'd0;
   assign digit_count = count_q;
   assign fail_count  = fail_q;
endmodule
